// File: rtl/counter_bank_led.sv
// counter_bank_led
//   A shared prescaler drives CHANNELS independent BITS-wide counters. Each
//   counter's mode (hold/up/down/clear) comes from a pair of synchronised
//   switch inputs. Tick, per-channel wrap and switch parity are exported as
//   status for other bring-up logic.
//
// Ports
//   clk     in   1              board clock (post-BUFG), rising edge
//   rst_n   in   1              asynchronous active-low reset
//   sw      in   2*CHANNELS     raw switches; sw[2c+1:2c] = mode of channel c
//   led     out  CHANNELS*BITS  counter values; led[c*BITS +: BITS] = channel c
//   tick    out  1              one-cycle pulse on each prescaler wrap
//   wrap    out  CHANNELS       one-cycle pulse when a channel counter wraps
//   sw_par  out  1              registered XOR of the synchronised switches
//
// Timing: tick, the counter updates and wrap all happen on the same edge (the
// edge on which the prescaler rolls over from all-ones to zero). The mode used
// is the synchroniser output present in the cycle leading up to that edge, so
// led, tick and wrap are always mutually aligned.
module counter_bank_led #(
    parameter int CHANNELS    = 2,
    parameter int BITS        = 4,
    parameter int LOG2DELAY   = 22,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*CHANNELS-1:0]    sw,
    output logic [CHANNELS*BITS-1:0] led,
    output logic                     tick,
    output logic [CHANNELS-1:0]      wrap,
    output logic                     sw_par
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DOWN  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_t;

    logic [LOG2DELAY-1:0]  presc_q;
    logic                  presc_roll;
    logic                  tick_q;
    logic [2*CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [2*CHANNELS-1:0] sw_synced;
    logic                  sw_par_q;
    logic [BITS-1:0]       cnt_q [CHANNELS];
    logic [BITS-1:0]       cnt_d [CHANNELS];
    logic [CHANNELS-1:0]   wrap_q;
    logic [CHANNELS-1:0]   wrap_d;

    // Free-running prescaler; never gated by any channel mode.
    assign presc_roll = (presc_q == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_q + 1'b1;
            tick_q  <= presc_roll;
        end
    end

    // Plain flop chain, no debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sw_par_q <= 1'b0;
        end else begin
            sync_q[0] <= sw;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sw_par_q <= ^sync_q[SYNC_STAGES-1];
        end
    end

    assign sw_synced = sync_q[SYNC_STAGES-1];

    // Channel next-state: only acts on the prescaler roll-over edge.
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            cnt_d[c]  = cnt_q[c];
            wrap_d[c] = 1'b0;
            if (presc_roll) begin
                case (mode_t'(sw_synced[2*c +: 2]))
                    MODE_HOLD: begin
                        cnt_d[c] = cnt_q[c];
                    end
                    MODE_UP: begin
                        cnt_d[c]  = cnt_q[c] + 1'b1;
                        wrap_d[c] = (cnt_q[c] == '1);
                    end
                    MODE_DOWN: begin
                        cnt_d[c]  = cnt_q[c] - 1'b1;
                        wrap_d[c] = (cnt_q[c] == '0);
                    end
                    MODE_CLEAR: begin
                        cnt_d[c] = '0;
                    end
                    default: begin
                        cnt_d[c] = cnt_q[c];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= '0;
            end
            wrap_q <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        led = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            led[c*BITS +: BITS] = cnt_q[c];
        end
    end

    assign tick   = tick_q;
    assign wrap   = wrap_q;
    assign sw_par = sw_par_q;

endmodule

// File: tb/tb_counter_bank_led.sv
module tb_counter_bank_led;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic [7:0] led;
    logic       tick;
    logic [1:0] wrap;
    logic       sw_par;

    int n_cmp;
    int n_err;

    counter_bank_led #(
        .CHANNELS   (2),
        .BITS       (4),
        .LOG2DELAY  (2),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .led   (led),
        .tick  (tick),
        .wrap  (wrap),
        .sw_par(sw_par)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // 1. Reset state and tick period, both channels UP
        rst_n = 1'b0;
        sw    = 4'b0101;
        edges(2);
        check("rst_led",    32'(led),    32'h00);
        check("rst_tick",   32'(tick),   32'h0);
        check("rst_wrap",   32'(wrap),   32'h0);
        check("rst_sw_par", 32'(sw_par), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            edges(1);
            check($sformatf("period_tick_e%0d", k), 32'(tick), (k % 4 == 0) ? 32'h1 : 32'h0);
            check($sformatf("period_wrap_e%0d", k), 32'(wrap), 32'h0);
        end
        check("period_led_after_2_ticks", 32'(led), 32'h22);

        // 2. ch0 UP, ch1 HOLD, 16 ticks from reset
        rst_n = 1'b0;
        sw    = 4'b0001;
        edges(2);
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            edges(4);
            check($sformatf("up_led_t%0d", t),  32'(led),  32'(t % 16));
            check($sformatf("up_wrap_t%0d", t), 32'(wrap), (t == 16) ? 32'h1 : 32'h0);
            check($sformatf("up_tick_t%0d", t), 32'(tick), 32'h1);
        end

        // 3. ch1 DOWN from 0, ch0 HOLD
        sw = 4'b1000;
        edges(4);
        check("down_led_1",  32'(led),  32'hF0);
        check("down_wrap_1", 32'(wrap), 32'h2);
        edges(1);
        check("down_wrap_clears", 32'(wrap), 32'h0);
        edges(3);
        check("down_led_2",  32'(led),  32'hE0);
        check("down_wrap_2", 32'(wrap), 32'h0);

        // 4. ch0 up to 9, then CLEAR landing on a tick, then a late switch
        sw = 4'b0001;
        edges(36);
        check("pre_clear_led", 32'(led), 32'hE9);
        edges(1);
        sw = 4'b0011;
        edges(3);
        check("clear_tick", 32'(tick), 32'h1);
        check("clear_led",  32'(led),  32'hE0);
        check("clear_wrap", 32'(wrap), 32'h0);
        sw = 4'b0001;
        edges(4);
        check("reup_led", 32'(led), 32'hE1);
        edges(2);
        sw = 4'b0011;
        edges(2);
        check("late_tick", 32'(tick), 32'h1);
        check("late_led",  32'(led),  32'hE2);
        edges(4);
        check("late_then_clear_led", 32'(led), 32'hE0);

        // 5. Synchroniser latency seen through sw_par
        check("par_before", 32'(sw_par), 32'h0);
        sw = 4'b0010;
        edges(2);
        check("par_2_edges", 32'(sw_par), 32'h0);
        edges(1);
        check("par_3_edges", 32'(sw_par), 32'h1);

        // 6. Async reset between edges; ch0 DOWN wraps at this edge
        @(posedge clk);
        #1;
        check("pre_arst_led",  32'(led),  32'hEF);
        check("pre_arst_wrap", 32'(wrap), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_led",    32'(led),    32'h00);
        check("arst_tick",   32'(tick),   32'h0);
        check("arst_wrap",   32'(wrap),   32'h0);
        check("arst_sw_par", 32'(sw_par), 32'h0);
        sw = 4'b0001;
        edges(2);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            edges(1);
            check($sformatf("post_arst_tick_e%0d", k), 32'(tick), (k == 4) ? 32'h1 : 32'h0);
            check($sformatf("post_arst_wrap_e%0d", k), 32'(wrap), 32'h0);
        end
        check("post_arst_led", 32'(led), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
